// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes engine: rebuilds the inverse S-box from the forward sbox after every reset, then substitutes LANES bytes per cycle.
// A block takes 16/LANES cycles; the result holds in DONE until out_ready, and no new input is taken meanwhile.

module sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   logic [7:0] w_inv;

   always_comb begin
      w_inv = gf_inv(din);
      dout  = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
            ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
   end
endmodule

module inv_sub_bytes_seq #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         init_done
);
   typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_DONE} state_t;

   state_t       r_state;
   state_t       w_next;
   logic [7:0]   r_icnt;
   logic [3:0]   r_ptr;
   logic [127:0] r_buf;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         r_init_done;
   logic [7:0]   r_inv_tab [0:256-1];
   logic [7:0]   w_sbox_out;
   logic [4:0]   w_ptr_sum;
   logic [127:0] w_buf_nxt;

   sbox u_sbox (
      .din  (r_icnt),
      .dout (w_sbox_out)
   );

   // The table has no reset: the forward S-box is a bijection, so the sweep rewrites every entry.
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) r_inv_tab[w_sbox_out] <= r_icnt;
   end

   // Bit 4 of the pointer sum marks the wrap from 16 back to 0, i.e. the last BUSY cycle.
   assign w_ptr_sum = {1'b0, r_ptr} + 5'(LANES);

   always_comb begin
      w_buf_nxt = r_buf;
      for (int j = 0; j < LANES; j++) begin
         w_buf_nxt[{r_ptr + 4'(j), 3'b000} +: 8] = r_inv_tab[r_buf[{r_ptr + 4'(j), 3'b000} +: 8]];
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_INIT: if (r_icnt == 8'hff) w_next = S_IDLE;
         S_IDLE: if (in_valid)        w_next = S_BUSY;
         S_BUSY: if (w_ptr_sum[4])    w_next = S_DONE;
         S_DONE: if (out_ready)       w_next = S_IDLE;
         default:                     w_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_INIT;
         r_icnt      <= 8'h00;
         r_ptr       <= 4'h0;
         r_buf       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == S_IDLE);
         r_out_valid <= (w_next == S_DONE);
         r_init_done <= (w_next != S_INIT);
         case (r_state)
            S_INIT: r_icnt <= r_icnt + 8'd1;
            S_IDLE: begin
               if (in_valid) begin
                  r_buf <= in_data;
                  r_ptr <= 4'h0;
               end
            end
            S_BUSY: begin
               r_buf <= w_buf_nxt;
               r_ptr <= w_ptr_sum[3:0];
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign init_done = r_init_done;
   assign out_data  = r_buf;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: five instances (LANES 4,1,2,8,16) checked against a table-based AES model.
module tb_inv_sub_bytes_seq;
   localparam int ND = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [ND];
   logic         in_ready  [ND];
   logic         out_valid [ND];
   logic         out_ready [ND];
   logic         init_done [ND];
   logic [127:0] in_data   [ND];
   logic [127:0] out_data  [ND];

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] sb [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
   logic [7:0] isb [0:255];

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < ND; g++) begin : g_dut
         localparam int L = (g == 0) ? 4 : ((g == 3) ? 8 : ((g == 4) ? 16 : g));
         inv_sub_bytes_seq #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .init_done (init_done[g])
         );
      end
   endgenerate

   function automatic int lanes_of(input int k);
      return (k == 0) ? 4 : ((k == 3) ? 8 : ((k == 4) ? 16 : k));
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = isb[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one block through instance k; ok=0 if any bounded wait expires.
   task automatic run_block(input int k, input logic [127:0] d, output logic [127:0] res,
                            output int lat, output bit ok);
      int w;
      ok  = 1'b1;
      lat = 0;
      res = '0;
      w   = 0;
      while (!in_ready[k] && w < 600) begin
         tick();
         w++;
      end
      if (!in_ready[k]) begin
         ok = 1'b0;
         return;
      end
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      tick();
      in_valid[k] = 1'b0;
      while (!out_valid[k] && lat < 40) begin
         tick();
         lat++;
      end
      if (!out_valid[k]) begin
         ok = 1'b0;
         return;
      end
      res = out_data[k];
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
   endtask

   task automatic test_reset();
      bit early;
      rst = 1'b1;
      for (int k = 0; k < ND; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
         in_data[k]   = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
         n_checks++;
         if ({in_ready[k], out_valid[k], init_done[k]} !== 3'b000 || out_data[k] !== '0)
            $display("FAIL reset_values dut%0d: rdy=%b vld=%b done=%b data=%h, want all 0",
                     k, in_ready[k], out_valid[k], init_done[k], out_data[k]);
         else n_pass++;
      end
      for (int k = 0; k < ND; k++) begin
         in_valid[k] = 1'b1;
         in_data[k]  = rand128();
      end
      rst   = 1'b0;
      early = 1'b0;
      for (int e = 1; e <= 256; e++) begin
         tick();
         if (e < 256)
            for (int k = 0; k < ND; k++)
               if (init_done[k] || in_ready[k] || out_valid[k]) early = 1'b1;
      end
      n_checks++;
      if (early !== 1'b0) $display("FAIL init_early: outputs rose before edge 256 (got %b, want 0)", early);
      else n_pass++;
      for (int k = 0; k < ND; k++) begin
         n_checks++;
         if ({init_done[k], in_ready[k], out_valid[k]} !== 3'b110)
            $display("FAIL init_edge256 dut%0d: done/rdy/vld=%b, want 110", k,
                     {init_done[k], in_ready[k], out_valid[k]});
         else n_pass++;
      end
      for (int k = 0; k < ND; k++) in_valid[k] = 1'b0;
      tick();
      n_checks++;
      if (in_ready[0] !== 1'b1) $display("FAIL init_no_accept: in_ready=%b, want 1", in_ready[0]);
      else n_pass++;
   endtask

   task automatic test_known_vector();
      logic [127:0] d, exp, res;
      int lat;
      bit ok;
      for (int i = 0; i < 16; i++) begin
         d[8*i +: 8]   = sb[i];
         exp[8*i +: 8] = 8'(i);
      end
      run_block(0, d, res, lat, ok);
      n_checks++;
      if (!ok || res !== exp) $display("FAIL known_vector: got %h ok=%b, want %h", res, ok, exp);
      else n_pass++;
      n_checks++;
      if (lat !== 4) $display("FAIL known_latency: got %0d, want 4", lat);
      else n_pass++;
   endtask

   task automatic test_single_bytes();
      logic [7:0] ins  [5] = '{8'h63, 8'h7c, 8'hed, 8'h16, 8'h52};
      logic [7:0] exps [5] = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h48};
      logic [127:0] d, res;
      int lat;
      bit ok;
      d = rand128();
      for (int i = 0; i < 5; i++) d[8*(3*i) +: 8] = ins[i];
      run_block(0, d, res, lat, ok);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (!ok || res[8*(3*i) +: 8] !== exps[i])
            $display("FAIL single_byte %h: got %h, want %h", ins[i], res[8*(3*i) +: 8], exps[i]);
         else n_pass++;
      end
   endtask

   task automatic test_sweep();
      int perm [256];
      logic [127:0] d, res;
      int lat, j, tmp, bad;
      bit ok;
      for (int k = 0; k < ND; k++) begin
         for (int i = 0; i < 256; i++) perm[i] = i;
         for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
         end
         for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(perm[16*b + i]);
            run_block(k, d, res, lat, ok);
            n_checks++;
            if (!ok || lat !== 16 / lanes_of(k))
               $display("FAIL sweep_latency L=%0d blk%0d: got %0d ok=%b, want %0d",
                        lanes_of(k), b, lat, ok, 16 / lanes_of(k));
            else n_pass++;
            bad = 0;
            for (int i = 0; i < 16; i++) if (sb[res[8*i +: 8]] !== d[8*i +: 8]) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL sweep_roundtrip L=%0d blk%0d: got %h for in %h (%0d bad lanes)",
                                   lanes_of(k), b, res, d, bad);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] d, res;
      int lat;
      bit ok;
      for (int n = 0; n < 20; n++) begin
         d = rand128();
         run_block(0, d, res, lat, ok);
         n_checks++;
         if (!ok || res !== model(d)) $display("FAIL random_block %0d: got %h, want %h", n, res, model(d));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int acc [2];
      int cyc, na, w;
      for (int k = 0; k < ND; k++) begin
         out_ready[k] = 1'b1;
         in_valid[k]  = 1'b1;
         in_data[k]   = rand128();
         cyc = 0;
         na  = 0;
         while (na < 2 && cyc < 200) begin
            if (in_ready[k]) begin
               acc[na] = cyc + 1;
               na++;
            end
            tick();
            cyc++;
         end
         in_valid[k] = 1'b0;
         w = 0;
         while (!in_ready[k] && w < 60) begin
            tick();
            w++;
         end
         out_ready[k] = 1'b0;
         n_checks++;
         if (na != 2 || acc[1] - acc[0] != 16 / lanes_of(k) + 2)
            $display("FAIL back_to_back L=%0d: spacing %0d (accepts %0d), want %0d",
                     lanes_of(k), acc[1] - acc[0], na, 16 / lanes_of(k) + 2);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] d, exp;
      int w;
      d   = rand128();
      exp = model(d);
      w   = 0;
      while (!in_ready[0] && w < 60) begin tick(); w++; end
      in_valid[0] = 1'b1;
      in_data[0]  = d;
      tick();
      in_data[0]  = rand128();
      w = 0;
      while (!out_valid[0] && w < 40) begin tick(); w++; end
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_data[0] !== exp)
            $display("FAIL backpressure_hold c%0d: vld=%b rdy=%b data=%h, want 1 0 %h",
                     c, out_valid[0], in_ready[0], out_data[0], exp);
         else n_pass++;
      end
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      n_checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1)
         $display("FAIL backpressure_release: vld=%b rdy=%b, want 0 1", out_valid[0], in_ready[0]);
      else n_pass++;
      tick();
      n_checks++;
      if (in_ready[0] !== 1'b1) $display("FAIL backpressure_ignored_input: rdy=%b, want 1", in_ready[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [127:0] res;
      int lat, w;
      bit ok, early;
      w = 0;
      while (!in_ready[0] && w < 60) begin tick(); w++; end
      in_valid[0] = 1'b1;
      in_data[0]  = rand128();
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid[0] !== 1'b0 || init_done[0] !== 1'b0 || in_ready[0] !== 1'b0 || out_data[0] !== '0)
         $display("FAIL reset_mid_async: vld=%b done=%b rdy=%b data=%h, want 0 0 0 0",
                  out_valid[0], init_done[0], in_ready[0], out_data[0]);
      else n_pass++;
      tick();
      rst   = 1'b0;
      early = 1'b0;
      for (int e = 1; e <= 256; e++) begin
         tick();
         if (e < 256 && (init_done[0] || in_ready[0])) early = 1'b1;
      end
      n_checks++;
      if (early !== 1'b0 || init_done[0] !== 1'b1 || in_ready[0] !== 1'b1)
         $display("FAIL reset_mid_reinit: early=%b done=%b rdy=%b, want 0 1 1", early, init_done[0], in_ready[0]);
      else n_pass++;
      run_block(0, {16{8'h63}}, res, lat, ok);
      n_checks++;
      if (!ok || res !== '0 || lat !== 4)
         $display("FAIL reset_mid_fresh_block: got %h lat=%0d ok=%b, want 0 lat=4", res, lat, ok);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
      test_reset();
      test_known_vector();
      test_single_bytes();
      test_sweep();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule
